f8_mem_sched: RTL and testbench
===============================

// Module: f8_mem_sched
// PURPOSE
//  Schedules one single-ported, 16-bit-wide, byte-enabled RAM among the three f8 CPU memory requesters:
//  instruction fetch (24 bit), data read (16 bit) and data write (byte/word).
//  Splits unaligned byte-addressed accesses into word cycles, assembles the results and pulses completion.
//  Sits between cpu and the RAM macro; the CPU stalls while its request is pending.
// PARAMETERS
//  MEM_AW  15  word-address width of the RAM (byte address = {word, lane}); word addresses wrap modulo 2**MEM_AW
// PORTS
//  clk          in   1       single clock, all state on posedge
//  reset        in   1       asynchronous, active-low reset (0 = in reset)
//  iread_req    in   1       fetch request; held high until iread_valid
//  iread_addr   in   16      fetch byte address; stable while iread_req is high
//  iread_data   out  24      fetched bytes; [7:0] = byte at iread_addr (opcode)
//  iread_valid  out  1       one-cycle completion pulse
//  dread_req    in   1       data read request; held high until dread_valid
//  dread_addr   in   16      data read byte address
//  dread_data   out  16      little-endian word read from dread_addr
//  dread_valid  out  1       one-cycle completion pulse
//  dwrite_en    in   2       byte enables; nonzero = write request; 01 = byte, 11 = word (10 illegal, treated as 01)
//  dwrite_addr  in   16      write byte address
//  dwrite_data  in   16      write data; [7:0] goes to dwrite_addr
//  dwrite_done  out  1       one-cycle completion pulse
//  mem_addr     out  MEM_AW  RAM word address (registered)
//  mem_re       out  1       RAM read strobe; mem_rdata valid in the following cycle
//  mem_we       out  2       RAM byte-lane write enables (registered)
//  mem_wdata    out  16      RAM write data (registered)
//  mem_rdata    in   16      RAM read data, 1-cycle latency
// BEHAVIOUR
//  - Reset: state IDLE; mem_re = 0, mem_we = 0, all valid/done = 0; iread_data, dread_data, mem_addr and mem_wdata = 0.
//  - Arbitration happens only in IDLE. Priority is dwrite > dread > iread. Losers keep their req high.
//  - Byte mapping: byte address A maps to word A[15:1], lane A[0]; little-endian.
//  - Write, aligned word or single byte: WR0 at T+1 (mem_we = lane mask), DONE at T+2 (dwrite_done = 1).
//  - Write, word at odd A: WR0 at T+1 writes lane 1 of word W with data[7:0].
//    WR1 at T+2 writes lane 0 of word W+1 with data[15:8]. dwrite_done at T+3.
//  - Read, word at even A: RD0 at T+1, captured at T+2, dread_valid at T+3.
//    Word at odd A: two word reads at T+1 and T+2, dread_valid at T+4.
//  - Fetch always performs two word reads (W, W+1), so iread_valid is at T+4.
//    Even A: data = {W+1.lo, W.hi, W.lo}. Odd A: data = {W+1.hi, W+1.lo, W.hi}.
//  - T is the IDLE cycle in which the request is sampled. Reads are issued back-to-back.
//    The first word is held in a capture register until the second word arrives.
//  - States: IDLE, WR0, WR1, RD0, RD1, RCAP, DONE.
//    DONE drives the single pulse and returns to IDLE. DONE is never an arbitration cycle, so a req
//    still high in the pulse cycle is not re-serviced; a req still high in the following IDLE starts a new access.
//  - Wrap: word W = 2**MEM_AW-1 with a second word gives next word 0.
//  - Request inputs are sampled only in IDLE. Changes mid-transaction are ignored; the transaction completes and pulses.
//  - Outputs iread_data and dread_data hold their last value after the pulse.
//  - Asynchronous reset mid-transaction aborts immediately: mem_we/mem_re drop and no completion pulse is issued.
//  - mem_re and mem_we are never both nonzero in the same cycle.
// STRUCTURE
//  - f8_mem_pkg: memsched_state_t enum, memsrc_t enum {SRC_NONE, SRC_DW, SRC_DR, SRC_IF},
//    lane/word split helper functions.
//  - Sub-module f8_byte_align (combinational): computes per-word lane masks and write-data placement from
//    (addr[0], width, dwrite_en), and assembles the 16/24-bit read result from two words.
//  - The top module contains the FSM, the grant register, the word-address incrementer and the capture register.
// TESTING
//  1. Reset low mid-RD1, then high:
//     mem_re = 0 immediately, no dread_valid, next IDLE services the pending request afresh.
//  2. RAM w0 = 0x0201, w1 = 0x0403; iread at 0x0000:
//     iread_data = 0x030201 at T+4.
//     Same RAM, iread at 0x0001: iread_data = 0x040302.
//  3. dwrite_en = 11, addr 0x0005, data 0xBEEF:
//     cycle 1: mem_addr 2, mem_we 10, mem_wdata[15:8] = 0xEF;
//     cycle 2: mem_addr 3, mem_we 01, mem_wdata[7:0] = 0xBE;
//     dwrite_done at T+3.
//  4. dwrite (addr 0x0010, byte 0x55), dread (0x0020) and iread (0x4000) all raised in the same cycle:
//     served in order write, read, fetch; completion pulses at T+2, T+6, T+11.
//  5. MEM_AW = 15, dread at 0xFFFF with w7FFF = 0x12AA, w0000 = 0x3456:
//     mem_addr sequence 0x7FFF then 0x0000; dread_data = 0x5612.
//  6. dread_req held high through dread_valid:
//     no second access until the IDLE cycle after DONE; exactly one valid pulse per transaction.

Source files
------------

// File: rtl/f8_mem_pkg.sv
// f8 memory scheduler shared types: FSM states, requester ids and
// byte-address split helpers.
package f8_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4,
        ST_RCAP = 3'd5,
        ST_DONE = 3'd6
    } memsched_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DW   = 2'd1,
        SRC_DR   = 2'd2,
        SRC_IF   = 2'd3
    } memsrc_t;

    function automatic logic [14:0] word_of(input logic [15:0] a);
        return a[15:1];
    endfunction

    function automatic logic lane_of(input logic [15:0] a);
        return a[0];
    endfunction

endpackage

// File: rtl/f8_byte_align.sv
// Lane steering for the 16-bit RAM: write masks/data placement and
// assembly of 16/24-bit little-endian read results from two words.
module f8_byte_align (
    input  logic        wr_lane,
    input  logic [1:0]  wr_en,
    input  logic [15:0] wr_data,
    output logic        wr_split,
    output logic [1:0]  we0,
    output logic [15:0] wd0,
    output logic [15:0] wd1,
    input  logic        rd_lane,
    input  logic [15:0] rw0,
    input  logic [15:0] rw1,
    output logic [15:0] rd16,
    output logic [23:0] rd24
);

    logic wr_word;

    assign wr_word  = (wr_en == 2'b11);
    assign wr_split = wr_word & wr_lane;
    // Second word of a split write always carries the high byte in lane 0.
    assign wd1      = {8'h00, wr_data[15:8]};

    always_comb begin
        we0 = 2'b01;
        wd0 = {8'h00, wr_data[7:0]};
        if (wr_word && !wr_lane) begin
            we0 = 2'b11;
            wd0 = wr_data;
        end else if (wr_lane) begin
            we0 = 2'b10;
            wd0 = {wr_data[7:0], 8'h00};
        end
    end

    assign rd16 = rd_lane ? {rw1[7:0], rw0[15:8]} : rw0;
    assign rd24 = rd_lane ? {rw1, rw0[15:8]} : {rw1[7:0], rw0};

endmodule

// File: rtl/f8_mem_sched.sv
// Single-port RAM scheduler for f8 fetch, data read and data write;
// splits unaligned accesses into word cycles and pulses completion.
module f8_mem_sched
    import f8_mem_pkg::*;
#(
    parameter int MEM_AW = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iread_req,
    input  logic [15:0]       iread_addr,
    output logic [23:0]       iread_data,
    output logic              iread_valid,
    input  logic              dread_req,
    input  logic [15:0]       dread_addr,
    output logic [15:0]       dread_data,
    output logic              dread_valid,
    input  logic [1:0]        dwrite_en,
    input  logic [15:0]       dwrite_addr,
    input  logic [15:0]       dwrite_data,
    output logic              dwrite_done,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic [1:0]        mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] WR0  = ST_WR0;
    localparam logic [2:0] WR1  = ST_WR1;
    localparam logic [2:0] RD0  = ST_RD0;
    localparam logic [2:0] RD1  = ST_RD1;
    localparam logic [2:0] RCAP = ST_RCAP;
    localparam logic [2:0] DONE = ST_DONE;

    logic [2:0]        state;
    memsrc_t           src;
    logic              lane_q;
    logic              two_q;
    logic [15:0]       cap;
    logic [15:0]       wr1_data;

    logic              wr_split;
    logic [1:0]        we0;
    logic [15:0]       wd0;
    logic [15:0]       wd1;
    logic [15:0]       rw0;
    logic [15:0]       rd16;
    logic [23:0]       rd24;
    logic [MEM_AW-1:0] addr_nx;

    // Single-word reads see their only word directly on mem_rdata.
    assign rw0     = two_q ? cap : mem_rdata;
    assign addr_nx = mem_addr + MEM_AW'(1);

    f8_byte_align u_align (
        .wr_lane  (lane_of(dwrite_addr)),
        .wr_en    (dwrite_en),
        .wr_data  (dwrite_data),
        .wr_split (wr_split),
        .we0      (we0),
        .wd0      (wd0),
        .wd1      (wd1),
        .rd_lane  (lane_q),
        .rw0      (rw0),
        .rw1      (mem_rdata),
        .rd16     (rd16),
        .rd24     (rd24)
    );

    assign dwrite_done = (state == DONE) && (src == SRC_DW);
    assign dread_valid = (state == DONE) && (src == SRC_DR);
    assign iread_valid = (state == DONE) && (src == SRC_IF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            src        <= SRC_NONE;
            lane_q     <= 1'b0;
            two_q      <= 1'b0;
            cap        <= '0;
            wr1_data   <= '0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 2'b00;
            mem_wdata  <= '0;
            iread_data <= '0;
            dread_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dwrite_en != 2'b00) begin
                        src       <= SRC_DW;
                        state     <= WR0;
                        mem_addr  <= MEM_AW'(word_of(dwrite_addr));
                        mem_we    <= we0;
                        mem_wdata <= wd0;
                        wr1_data  <= wd1;
                        two_q     <= wr_split;
                    end else if (dread_req) begin
                        src      <= SRC_DR;
                        state    <= RD0;
                        mem_addr <= MEM_AW'(word_of(dread_addr));
                        mem_re   <= 1'b1;
                        lane_q   <= lane_of(dread_addr);
                        two_q    <= lane_of(dread_addr);
                    end else if (iread_req) begin
                        src      <= SRC_IF;
                        state    <= RD0;
                        mem_addr <= MEM_AW'(word_of(iread_addr));
                        mem_re   <= 1'b1;
                        lane_q   <= lane_of(iread_addr);
                        two_q    <= 1'b1;
                    end else begin
                        src <= SRC_NONE;
                    end
                end
                WR0: begin
                    if (two_q) begin
                        state     <= WR1;
                        mem_addr  <= addr_nx;
                        mem_we    <= 2'b01;
                        mem_wdata <= wr1_data;
                    end else begin
                        state  <= DONE;
                        mem_we <= 2'b00;
                    end
                end
                WR1: begin
                    state  <= DONE;
                    mem_we <= 2'b00;
                end
                RD0: begin
                    if (two_q) begin
                        state    <= RD1;
                        mem_addr <= addr_nx;
                    end else begin
                        state  <= RCAP;
                        mem_re <= 1'b0;
                    end
                end
                RD1: begin
                    state  <= RCAP;
                    mem_re <= 1'b0;
                    cap    <= mem_rdata;
                end
                RCAP: begin
                    state <= DONE;
                    if (src == SRC_IF) begin
                        iread_data <= rd24;
                    end else begin
                        dread_data <= rd16;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f8_mem_sched.sv
// Directed vector bench for f8_mem_sched with a behavioural 1-cycle RAM.
module tb_f8_mem_sched;

    typedef struct {
        int          kind;
        logic [1:0]  en;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [23:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iread_req = 1'b0;
    logic [15:0] iread_addr = '0;
    logic [23:0] iread_data;
    logic        iread_valid;
    logic        dread_req = 1'b0;
    logic [15:0] dread_addr = '0;
    logic [15:0] dread_data;
    logic        dread_valid;
    logic [1:0]  dwrite_en = '0;
    logic [15:0] dwrite_addr = '0;
    logic [15:0] dwrite_data = '0;
    logic        dwrite_done;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic [1:0]  mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] ram [0:32767];
    logic        pre_en = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [16];

    f8_mem_sched #(.MEM_AW(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .iread_req   (iread_req),
        .iread_addr  (iread_addr),
        .iread_data  (iread_data),
        .iread_valid (iread_valid),
        .dread_req   (dread_req),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dread_valid (dread_valid),
        .dwrite_en   (dwrite_en),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_done (dwrite_done),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we[0]) ram[mem_addr][7:0] <= mem_wdata[7:0];
        if (mem_we[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_re && (mem_we != 2'b00)) begin
            chk("re_we_exclusive", 32'(mem_we), 32'd0);
        end
    end

    task automatic poke(input logic [14:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    function automatic logic pulse_of(input int kind);
        if (kind == 0) return dwrite_done;
        if (kind == 1) return dread_valid;
        return iread_valid;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        if (v.kind == 0) begin
            dwrite_en = v.en;
            dwrite_addr = v.addr;
            dwrite_data = v.wdata;
        end else if (v.kind == 1) begin
            dread_req = 1'b1;
            dread_addr = v.addr;
        end else begin
            iread_req = 1'b1;
            iread_addr = v.addr;
        end
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(posedge clk);
            #1;
            if (pulse_of(v.kind)) n = k;
        end
        dwrite_en = 2'b00;
        dread_req = 1'b0;
        iread_req = 1'b0;
        chk($sformatf("vec%0d_latency", idx), 32'(n), 32'(v.lat));
        if (v.kind == 1) begin
            chk($sformatf("vec%0d_dread_data", idx), 32'(dread_data), 32'(v.exp));
        end else if (v.kind == 2) begin
            chk($sformatf("vec%0d_iread_data", idx), 32'(iread_data), 32'(v.exp));
        end
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_pulse_single", idx), 32'(pulse_of(v.kind)), 32'd0);
    endtask

    initial begin
        int tw;
        int tr;
        int ti;
        int np;
        int p1;
        int p2;
        int seen;

        tbl[0]  = '{2, 2'b00, 16'h0000, 16'h0000, 24'h030201, 4};
        tbl[1]  = '{2, 2'b00, 16'h0001, 16'h0000, 24'h040302, 4};
        tbl[2]  = '{1, 2'b00, 16'h0000, 16'h0000, 24'h000201, 3};
        tbl[3]  = '{1, 2'b00, 16'h0001, 16'h0000, 24'h000302, 4};
        tbl[4]  = '{0, 2'b11, 16'h0004, 16'hA1B2, 24'h000000, 2};
        tbl[5]  = '{1, 2'b00, 16'h0004, 16'h0000, 24'h00A1B2, 3};
        tbl[6]  = '{0, 2'b01, 16'h0007, 16'h0077, 24'h000000, 2};
        tbl[7]  = '{0, 2'b10, 16'h0006, 16'h0066, 24'h000000, 2};
        tbl[8]  = '{1, 2'b00, 16'h0006, 16'h0000, 24'h007766, 3};
        tbl[9]  = '{0, 2'b11, 16'h0009, 16'hC0DE, 24'h000000, 3};
        tbl[10] = '{1, 2'b00, 16'h0009, 16'h0000, 24'h00C0DE, 4};
        tbl[11] = '{2, 2'b00, 16'h0008, 16'h0000, 24'hC0DE00, 4};
        tbl[12] = '{0, 2'b11, 16'h0000, 16'h3456, 24'h000000, 2};
        tbl[13] = '{1, 2'b00, 16'hFFFF, 16'h0000, 24'h005612, 4};
        tbl[14] = '{2, 2'b00, 16'hFFFE, 16'h0000, 24'h5612AA, 4};
        tbl[15] = '{2, 2'b00, 16'h0003, 16'h0000, 24'hA1B204, 4};

        poke(15'h0000, 16'h0201);
        poke(15'h0001, 16'h0403);
        for (int a = 2; a <= 16; a++) poke(15'(a), 16'h0000);
        poke(15'h2000, 16'h0000);
        poke(15'h2001, 16'h0000);
        poke(15'h7FFF, 16'h12AA);

        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_iread_data", 32'(iread_data), 32'd0);
        chk("rst_dread_data", 32'(dread_data), 32'd0);
        chk("rst_pulses", 32'({iread_valid, dread_valid, dwrite_done}), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

        // split word write at an odd address
        @(negedge clk);
        dwrite_en = 2'b11;
        dwrite_addr = 16'h0005;
        dwrite_data = 16'hBEEF;
        @(posedge clk);
        #1;
        chk("wsplit_c1_addr", 32'(mem_addr), 32'd2);
        chk("wsplit_c1_we", 32'(mem_we), 32'd2);
        chk("wsplit_c1_hi", 32'(mem_wdata[15:8]), 32'hEF);
        @(posedge clk);
        #1;
        chk("wsplit_c2_addr", 32'(mem_addr), 32'd3);
        chk("wsplit_c2_we", 32'(mem_we), 32'd1);
        chk("wsplit_c2_lo", 32'(mem_wdata[7:0]), 32'hBE);
        chk("wsplit_c2_done", 32'(dwrite_done), 32'd0);
        @(posedge clk);
        #1;
        chk("wsplit_done", 32'(dwrite_done), 32'd1);
        chk("wsplit_we_off", 32'(mem_we), 32'd0);
        dwrite_en = 2'b00;
        @(posedge clk);
        #1;

        // word-address wrap on an unaligned read
        @(negedge clk);
        dread_req = 1'b1;
        dread_addr = 16'hFFFF;
        @(posedge clk);
        #1;
        chk("wrap_addr0", 32'(mem_addr), 32'h7FFF);
        chk("wrap_re0", 32'(mem_re), 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_addr1", 32'(mem_addr), 32'h0000);
        chk("wrap_re1", 32'(mem_re), 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_re_off", 32'(mem_re), 32'd0);
        @(posedge clk);
        #1;
        chk("wrap_valid", 32'(dread_valid), 32'd1);
        chk("wrap_data", 32'(dread_data), 32'h5612);
        dread_req = 1'b0;
        @(posedge clk);
        #1;

        // three simultaneous requesters
        tw = 0;
        tr = 0;
        ti = 0;
        @(negedge clk);
        dwrite_en = 2'b01;
        dwrite_addr = 16'h0010;
        dwrite_data = 16'h0055;
        dread_req = 1'b1;
        dread_addr = 16'h0020;
        iread_req = 1'b1;
        iread_addr = 16'h4000;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (dwrite_done) begin
                tw = k;
                dwrite_en = 2'b00;
            end
            if (dread_valid) begin
                tr = k;
                dread_req = 1'b0;
            end
            if (iread_valid) begin
                ti = k;
                iread_req = 1'b0;
            end
        end
        dwrite_en = 2'b00;
        dread_req = 1'b0;
        iread_req = 1'b0;
        chk("arb_write_t", 32'(tw), 32'd2);
        chk("arb_read_t", 32'(tr), 32'd6);
        chk("arb_fetch_t", 32'(ti), 32'd11);
        chk("arb_dread_data", 32'(dread_data), 32'h0000);
        chk("arb_iread_data", 32'(iread_data), 32'h000000);

        // request held through its pulse
        np = 0;
        p1 = 0;
        p2 = 0;
        @(negedge clk);
        dread_req = 1'b1;
        dread_addr = 16'h0000;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (dread_valid) begin
                np++;
                if (np == 1) p1 = k;
                if (np == 2) p2 = k;
            end
        end
        dread_req = 1'b0;
        chk("hold_first", 32'(p1), 32'd3);
        chk("hold_second", 32'(p2), 32'd7);
        chk("hold_count", 32'(np), 32'd5);
        chk("hold_data", 32'(dread_data), 32'h3456);
        @(posedge clk);
        #1;

        // asynchronous reset in the second read cycle
        @(negedge clk);
        dread_req = 1'b1;
        dread_addr = 16'h0001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_mid_re_before", 32'(mem_re), 32'd1);
        chk("rst_mid_addr_before", 32'(mem_addr), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_re", 32'(mem_re), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (dread_valid || mem_re) seen++;
        end
        chk("rst_mid_quiet", 32'(seen), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        np = 0;
        for (int k = 1; k <= 20 && np == 0; k++) begin
            @(posedge clk);
            #1;
            if (dread_valid) np = k;
        end
        dread_req = 1'b0;
        chk("rst_mid_retry_t", 32'(np), 32'd4);
        chk("rst_mid_retry_data", 32'(dread_data), 32'h0334);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
